// File: rtl/adc_stream_capture.sv
// Triggered ADC stream capture into a DEPTH-word buffer with decimation and a registered read port.
// Optional level trigger on signed ch1 is compiled in with `define ADC_CAPTURE_TRIG_EN.
//
// state   | meaning
// IDLE    | waiting for an arm rising edge
// ARMED   | waiting for the first beat that satisfies the trigger
// CAPTURE | storing every (decim+1)-th valid beat
// DONE    | buffer full, waiting for a new arm edge
module adc_stream_capture #(
  parameter int ADC_DATA_WIDTH   = 16,
  parameter int AXIS_TDATA_WIDTH = 32,
  parameter int DEPTH            = 256,
  localparam int ADDR_W          = $clog2(DEPTH)
) (
  input  logic                        clk,
  input  logic                        rst_ni,
  input  logic [AXIS_TDATA_WIDTH-1:0] S_AXIS_tdata_i,
  input  logic                        S_AXIS_tvalid_i,
  output logic                        S_AXIS_tready_o,
  input  logic                        arm_i,
  input  logic                        clear_i,
  input  logic [7:0]                  decim_i,
  input  logic [ADC_DATA_WIDTH-1:0]   trig_level_i,
  input  logic [ADDR_W-1:0]           rd_addr_i,
  output logic [AXIS_TDATA_WIDTH-1:0] rd_data_o,
  output logic                        busy_o,
  output logic                        done_o,
  output logic [ADDR_W:0]             wr_count_o
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W+1)'(DEPTH - 1);

  state_t                      state_q, state_d;
  logic                        ready_q;
  logic                        arm_q;
  logic                        arm_edge;
  logic                        beat;
  logic                        trig_hit;
  logic                        arm_load;
  logic                        store;
  logic                        cnt_adv;
  logic [7:0]                  decim_q;
  logic [7:0]                  decim_cnt;
  logic [ADDR_W:0]             wr_count_q;
  logic [AXIS_TDATA_WIDTH-1:0] mem [DEPTH];

  // ready_q marks the first cycle out of reset; gating arm_q with it means
  // an arm level held through reset is seen as an edge one cycle later.
  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      ready_q <= 1'b0;
      arm_q   <= 1'b0;
    end else begin
      ready_q <= 1'b1;
      arm_q   <= arm_i & ready_q;
    end
  end

  assign arm_edge        = ready_q & arm_i & ~arm_q;
  assign beat            = ready_q & S_AXIS_tvalid_i;
  assign S_AXIS_tready_o = ready_q;

`ifdef ADC_CAPTURE_TRIG_EN
  assign trig_hit = $signed(S_AXIS_tdata_i[ADC_DATA_WIDTH-1:0]) >= $signed(trig_level_i);
`else
  logic unused_trig_level;
  assign unused_trig_level = ^trig_level_i;
  assign trig_hit          = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    arm_load = 1'b0;
    store    = 1'b0;
    cnt_adv  = 1'b0;
    if (clear_i) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (arm_edge) begin
            arm_load = 1'b1;
            state_d  = ARMED;
          end
        end
        ARMED: begin
          if (beat && trig_hit) begin
            store   = 1'b1;
            cnt_adv = 1'b1;
            state_d = CAPTURE;
          end
        end
        CAPTURE: begin
          if (beat) begin
            cnt_adv = 1'b1;
            if (decim_cnt == 8'd0) begin
              store = 1'b1;
              if (wr_count_q == LAST_IDX) state_d = DONE;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      decim_q    <= 8'd0;
      decim_cnt  <= 8'd0;
      wr_count_q <= '0;
    end else if (arm_load) begin
      decim_q    <= decim_i;
      decim_cnt  <= 8'd0;
      wr_count_q <= '0;
    end else begin
      if (cnt_adv) decim_cnt <= (decim_cnt == decim_q) ? 8'd0 : decim_cnt + 8'd1;
      if (store)   wr_count_q <= wr_count_q + 1'b1;
    end
  end

  // Buffer contents are deliberately left unreset.
  always_ff @(posedge clk) begin
    if (store) mem[wr_count_q[ADDR_W-1:0]] <= S_AXIS_tdata_i;
  end

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) rd_data_o <= '0;
    else         rd_data_o <= mem[rd_addr_i];
  end

  assign busy_o     = (state_q == ARMED) || (state_q == CAPTURE);
  assign done_o     = (state_q == DONE);
  assign wr_count_o = wr_count_q;

endmodule

// File: tb/tb_adc_stream_capture.sv
// Directed bench for adc_stream_capture (DEPTH=16); buffer reads are checked through a
// scoreboard queue, status outputs are checked inline.
module tb_adc_stream_capture;

  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [31:0]       tdata;
  logic              tvalid;
  logic              tready;
  logic              arm;
  logic              clear;
  logic [7:0]        decim;
  logic [15:0]       trig_level;
  logic [ADDR_W-1:0] rd_addr;
  logic [31:0]       rd_data;
  logic              busy;
  logic              done;
  logic [ADDR_W:0]   wr_count;

  logic              rd_req;
  logic [31:0]       sb[$];
  int                total = 0;
  int                bad   = 0;

  adc_stream_capture #(
    .ADC_DATA_WIDTH  (16),
    .AXIS_TDATA_WIDTH(32),
    .DEPTH           (DEPTH)
  ) dut (
    .clk            (clk),
    .rst_ni         (rst_n),
    .S_AXIS_tdata_i (tdata),
    .S_AXIS_tvalid_i(tvalid),
    .S_AXIS_tready_o(tready),
    .arm_i          (arm),
    .clear_i        (clear),
    .decim_i        (decim),
    .trig_level_i   (trig_level),
    .rd_addr_i      (rd_addr),
    .rd_data_o      (rd_data),
    .busy_o         (busy),
    .done_o         (done),
    .wr_count_o     (wr_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Read monitor: a request seen at a posedge is answered by rd_data at the next negedge.
  initial begin
    logic        pend;
    logic [31:0] exp;
    forever begin
      @(posedge clk);
      pend = rd_req;
      @(negedge clk);
      if (pend) begin
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL rd_unexpected actual=%h required=none", rd_data);
        end else begin
          exp = sb.pop_front();
          if (rd_data !== exp) begin
            bad++;
            $display("FAIL rd_data actual=%h required=%h", rd_data, exp);
          end
        end
      end
    end
  end

  task automatic rd(input logic [ADDR_W-1:0] a, input logic [31:0] exp);
    @(negedge clk);
    rd_addr = a;
    rd_req  = 1'b1;
    sb.push_back(exp);
    @(negedge clk);
    rd_req  = 1'b0;
  endtask

  task automatic beat(input logic [31:0] d, input logic v);
    @(negedge clk);
    tdata  = d;
    tvalid = v;
  endtask

  task automatic arm_cycle(input logic [7:0] dc, input logic [15:0] tl);
    @(negedge clk);
    tvalid = 1'b0;
    arm    = 1'b0;
    @(negedge clk);
    arm        = 1'b1;
    decim      = dc;
    trig_level = tl;
    @(posedge clk);
    #1;
    chk("arm_busy", busy, 1'b1);
    chk("arm_wr_count", wr_count, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; tdata = '0; tvalid = 1'b0; arm = 1'b0; clear = 1'b0;
    decim = 8'd0; trig_level = 16'h8000; rd_addr = '0; rd_req = 1'b0;

    // Reset values, then arm held high across release: arms on second edge.
    repeat (2) @(negedge clk);
    chk("rst_tready", tready, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_wr_count", wr_count, 0);
    chk("rst_rd_data", rd_data, 0);
    rst_n = 1'b1;
    arm   = 1'b1;
    @(posedge clk); #1;
    chk("rel_edge1_busy", busy, 1'b0);
    chk("rel_tready", tready, 1'b1);
    @(posedge clk); #1;
    chk("rel_edge2_busy", busy, 1'b1);

    // decim=0, 20 counting beats: DONE after beat 16.
    for (int i = 0; i < 20; i++) begin
      beat({16'h1000 + 16'(i), 16'(i)}, 1'b1);
      if (i == 14) begin
        @(posedge clk); #1;
        chk("t1_done_early", done, 1'b0);
        chk("t1_count15", wr_count, 15);
      end
      if (i == 15) begin
        @(posedge clk); #1;
        chk("t1_done", done, 1'b1);
        chk("t1_count16", wr_count, 16);
      end
    end
    beat('0, 1'b0);
    repeat (3) @(negedge clk);
    chk("t1_no_wrap", wr_count, 16);
    chk("t1_arm_held_done", done, 1'b1);
    rd(4'd5, 32'h1005_0005);
    rd(4'd0, 32'h1000_0000);
    rd(4'd15, 32'h100F_000F);

    // Re-arm with decim=2 and toggling valid; decim input change after arm is ignored.
    arm_cycle(8'd2, 16'h8000);
    decim = 8'd5;
    for (int j = 0; j < 48; j++) begin
      beat({16'h2000, 16'(j)}, 1'b1);
      beat(32'hDEAD_BEEF, 1'b0);
    end
    @(negedge clk);
    chk("t2_done", done, 1'b1);
    chk("t2_count", wr_count, 16);
    rd(4'd0, 32'h2000_0000);
    rd(4'd1, 32'h2000_0003);
    rd(4'd2, 32'h2000_0006);
    rd(4'd7, 32'h2000_0015);
    rd(4'd15, 32'h2000_002D);

    // Trigger ramp: one negative beat, then ch1 0x00F0..0x0110.
    arm_cycle(8'd0, 16'h0100);
    beat(32'h3000_FF00, 1'b1);
    for (int r = 16'h00F0; r <= 16'h0110; r++) beat({16'h3000, 16'(r)}, 1'b1);
    beat('0, 1'b0);
    for (int k = 0; k < 10 && !done; k++) @(negedge clk);
    chk("t3_done", done, 1'b1);
`ifdef ADC_CAPTURE_TRIG_EN
    rd(4'd0, 32'h3000_0100);
    rd(4'd1, 32'h3000_0101);
    rd(4'd7, 32'h3000_0107);
`else
    rd(4'd0, 32'h3000_FF00);
    rd(4'd1, 32'h3000_00F0);
    rd(4'd7, 32'h3000_00F6);
`endif

    // Clear after 7 words with a simultaneous arm edge.
    arm_cycle(8'd0, 16'h8000);
    for (int i = 0; i < 7; i++) begin
      beat({16'h4000, 16'h0400 + 16'(i)}, 1'b1);
      if (i == 5) arm = 1'b0;
    end
    @(negedge clk);
    tdata  = 32'hBAD0_BAD0;
    tvalid = 1'b1;
    clear  = 1'b1;
    arm    = 1'b1;
    @(posedge clk); #1;
    chk("t4_busy", busy, 1'b0);
    chk("t4_done", done, 1'b0);
    chk("t4_count", wr_count, 7);
    @(negedge clk);
    clear  = 1'b0;
    tvalid = 1'b0;
    repeat (2) @(negedge clk);
    chk("t4_no_rearm", busy, 1'b0);
    chk("t4_count_hold", wr_count, 7);
    rd(4'd6, 32'h4000_0406);
`ifdef ADC_CAPTURE_TRIG_EN
    rd(4'd7, 32'h3000_0107);
`else
    rd(4'd7, 32'h3000_00F6);
`endif

    // Asynchronous reset mid-capture.
    arm_cycle(8'd0, 16'h8000);
    for (int i = 0; i < 3; i++) beat({16'h5000, 16'(i)}, 1'b1);
    rd_addr = 4'd6;
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_rst_busy", busy, 1'b0);
    chk("t5_rst_done", done, 1'b0);
    chk("t5_rst_count", wr_count, 0);
    chk("t5_rst_rd_data", rd_data, 0);
    chk("t5_rst_tready", tready, 1'b0);
    tvalid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    arm_cycle(8'd0, 16'h8000);
    beat(32'h6000_0001, 1'b1);
    beat('0, 1'b0);
    chk("t5_restart_count", wr_count, 1);

    repeat (4) @(negedge clk);
    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL sb_drain actual=%0d required=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/adc_stream_capture.md
ADC_STREAM_CAPTURE -- requirements
Module: adc_stream_capture

Interface
REQ-001 SHALL have parameter ADC_DATA_WIDTH, default 16, width of one ADC channel lane in the stream word.
REQ-002 SHALL have parameter AXIS_TDATA_WIDTH, default 32, stream word width (ch2 in [31:16], ch1 in [15:0]).
REQ-003 SHALL have parameter DEPTH, default 256, capture buffer depth in words; power of two, at least 4; ADDR_W = log2(DEPTH).
REQ-004 SHALL have port clk  input  1  capture clock (FCLK_CLK0, 125 MHz); single clock domain.
REQ-005 SHALL have port rst_ni  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port S_AXIS_tdata_i  input  AXIS_TDATA_WIDTH  packed ADC sample word.
REQ-007 SHALL have port S_AXIS_tvalid_i  input  1  sample-valid qualifier.
REQ-008 SHALL have port S_AXIS_tready_o  output  1  constant 1 outside reset; the block never back-pressures the ADC.
REQ-009 SHALL have port arm_i  input  1  arm request, level from the core's command register; rising edge acts.
REQ-010 SHALL have port clear_i  input  1  synchronous abort, level-sensitive, returns to IDLE.
REQ-011 SHALL have port decim_i  input  8  decimation: store every (decim_i+1)-th valid sample.
REQ-012 SHALL have port trig_level_i  input  ADC_DATA_WIDTH  signed ch1 trigger threshold.
REQ-013 SHALL have port rd_addr_i  input  ADDR_W  buffer read address.
REQ-014 SHALL have port rd_data_o  output  AXIS_TDATA_WIDTH  buffer read data, registered.
REQ-015 SHALL have port busy_o  output  1  high in ARMED or CAPTURE.
REQ-016 SHALL have port done_o  output  1  high in DONE.
REQ-017 SHALL have port wr_count_o  output  ADDR_W+1  words stored in the current or last capture.

Function
REQ-018 SHALL implement states IDLE, ARMED, CAPTURE, DONE.
REQ-019 SHALL register arm_i once and detect its rising edge (arm_i=1, previous=0); a level held high SHALL arm only once.
REQ-020 SHALL, on an arm edge in IDLE or DONE: latch decim_i, zero wr_count_o and the decimation counter, enter ARMED.
REQ-021 SHALL ignore arm edges in ARMED and CAPTURE.
REQ-022 SHALL move from ARMED to CAPTURE on the first valid beat that meets the trigger rule (REQ-036/037); that beat SHALL be stored at address 0.
REQ-023 SHALL, in CAPTURE, store a valid beat only when the decimation counter equals 0.
REQ-024 SHALL advance the decimation counter on every valid beat, wrapping from the latched decim value to 0; decim 0 stores every beat.
REQ-025 SHALL write the stored word at address wr_count_o[ADDR_W-1:0] and then increment wr_count_o.
REQ-026 SHALL enter DONE on the same edge the DEPTH-th word is written; wr_count_o then holds DEPTH and SHALL not wrap.
REQ-027 SHALL ignore valid beats in IDLE and DONE and invalid beats in every state.
REQ-028 SHALL, while clear_i=1, force IDLE, keep wr_count_o unchanged and hold the buffer contents; clear SHALL take priority over a simultaneous arm edge.
REQ-029 SHALL register rd_data_o with 1-cycle latency from rd_addr_i in every state; a read of the address being written in the same cycle SHALL return the old contents.
REQ-030 SHALL derive busy_o and done_o combinationally from the state register.

Reset
REQ-031 SHALL, while rst_ni=0, asynchronously force state IDLE, busy_o=0, done_o=0, wr_count_o=0, rd_data_o=0, S_AXIS_tready_o=0, and clear the arm edge register and decimation counter.
REQ-032 SHALL release reset synchronously to clk; the first arm edge is recognised on the second rising edge after deassertion at the earliest.
REQ-033 SHALL not initialise buffer contents on reset.
REQ-034 SHALL abort a capture in progress on reset; on re-arm, wr_count_o restarts from 0.

Configuration
REQ-035 SHALL use macro ADC_CAPTURE_TRIG_EN to compile the level trigger in or out.
REQ-036 SHALL, with ADC_CAPTURE_TRIG_EN defined, trigger on the first valid beat where signed ch1 (tdata[15:0]) >= signed trig_level_i.
REQ-037 SHALL, without ADC_CAPTURE_TRIG_EN, trigger on the first valid beat after entering ARMED and ignore trig_level_i.

Verification (DEPTH=16)
REQ-038 SHALL check: reset, arm edge, decim=0, 20 valid beats with counting data 0..19 -> DONE after beat 16, wr_count_o=16, addr 5 reads 5 one cycle later.
REQ-039 SHALL check: decim=2, tvalid toggling 1/0 each cycle -> stored words are beats 0,3,6,... of the valid beats only.
REQ-040 SHALL check: with TRIG_EN, trig_level=0x0100, ch1 ramp 0x00F0 to 0x0110 -> addr 0 holds ch1=0x0100.
REQ-041 SHALL check: clear_i asserted after 7 words, with a simultaneous arm edge -> IDLE, wr_count_o=7, buffer retained.
REQ-042 SHALL check: arm_i held high across DONE -> no re-arm; low then high -> new capture, wr_count_o restarts from 0.
REQ-043 SHALL check: rst_ni pulsed low mid-capture -> outputs at reset values immediately, without waiting for a clk edge.
